// File: rtl/spi_in_pkg.sv
// Shared constants for the serial receive blocks: word width, bit-counter
// width and the boolean constants used across them.
package spi_in_pkg;

    localparam int   WORD_WIDTH = 16;
    localparam int   CNT_WIDTH  = 4;
    localparam logic FALSE      = 1'b0;
    localparam logic TRUE       = 1'b1;

endpackage

// File: rtl/spi_in_fifo.sv
// First-word-fall-through receive FIFO. The head word is visible on readData
// whenever the FIFO is non-empty and reads as zero when empty.
module spi_in_fifo
    import spi_in_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] pushData,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] readData,
    output logic                  full,
    output logic                  empty,
    output logic [4:0]            level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic                  popOk;
    logic                  pushOk;

    assign empty    = (level == 5'd0);
    assign full     = (level == 5'(DEPTH));
    assign popOk    = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign pushOk   = push && (!full || popOk);
    assign readData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= 5'd0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            level <= level + 5'(pushOk) - 5'(popOk);
        end
    end

    always_ff @(posedge clock) begin
        if (pushOk) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/spi_in.sv
// Serial-to-parallel receiver: deserializes MSB-first 16-bit words framed by
// chipSelectN into a FWFT FIFO and keeps sticky overflow / frame-error flags.
module spi_in
    import spi_in_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  chipSelectN,
    input  logic                  MOSI,
    input  logic                  readAck,
    input  logic                  clearErrors,
    output logic [WORD_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic [4:0]            level,
    output logic                  overflow,
    output logic                  frameError
);

    // Read handshake: readValid is high while a word is held; a word is consumed
    // at any edge where readAck and readValid are both high. readAck alone is ignored.

    // Only 15 bits are stored: the 16th bit goes straight from MOSI into the word.
    logic [WORD_WIDTH-2:0] shiftReg;
    logic [CNT_WIDTH-1:0]  bitCount;
    logic                  wordDone;
    logic                  popOk;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  dropEvent;
    logic                  frameEvent;

    assign wordDone   = !chipSelectN && (bitCount == '1);
    assign readValid  = !fifoEmpty;
    assign popOk      = readAck && readValid;
    assign dropEvent  = wordDone && fifoFull && !popOk;
    assign frameEvent = chipSelectN && (bitCount != '0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bitCount <= '0;
            shiftReg <= '0;
        end else if (chipSelectN) begin
            bitCount <= '0;
            shiftReg <= '0;
        end else begin
            bitCount <= bitCount + CNT_WIDTH'(1);
            shiftReg <= {shiftReg[WORD_WIDTH-3:0], MOSI};
        end
    end

    // Error flags are sticky; a new event on the clearing edge keeps the flag set.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            overflow   <= FALSE;
            frameError <= FALSE;
        end else begin
            overflow   <= (overflow && !clearErrors) || dropEvent;
            frameError <= (frameError && !clearErrors) || frameEvent;
        end
    end

    spi_in_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetN   (resetN),
        .push     (wordDone),
        .pushData ({shiftReg, MOSI}),
        .pop      (readAck),
        .readData (readData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (level)
    );

endmodule
